// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: the per-stage writer record and
// the forward-select encoding for "read from the register file".
package hazard_scoreboard_pkg;

  // Register index storage is wide enough for any sane NREGS. Narrower
  // indices are zero-extended, so the stored value still compares exactly.
  localparam int RW_MAX = 16;
  localparam int FWD_RF = 0;

  typedef logic [RW_MAX-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t rd;
    logic     is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline and the hazard scoreboard.
// The master modport is the pipeline side; the slave modport is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
);
    localparam int RW = $clog2(NREGS);
    localparam int FW = $clog2(DEPTH + 1);

    // advance is the only handshake: the scoreboard commits one shift per
    // cycle in which advance is high; stall and fwd are combinational and
    // valid in the same cycle as the decode fields, with no ready feedback.
    logic              advance;
    logic              flush;
    logic              id_valid;
    logic [RW-1:0]     id_rs1;
    logic [RW-1:0]     id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [RW-1:0]     id_rd;
    logic              id_regwr;
    logic              id_is_load;

    logic              stall;
    logic [FW-1:0]     fwd1;
    logic [FW-1:0]     fwd2;
    logic [DEPTH-1:0]  sb_valid;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output advance, flush, id_valid, id_rs1, id_rs2, id_rs1_used,
               id_rs2_used, id_rd, id_regwr, id_is_load,
        input  stall, fwd1, fwd2, sb_valid, stall_cnt
    );

    modport slave (
        input  advance, flush, id_valid, id_rs1, id_rs2, id_rs1_used,
               id_rs2_used, id_rd, id_regwr, id_is_load,
        output stall, fwd1, fwd2, sb_valid, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_operand_match.sv
// Scans the scoreboard for one source operand and reports whether its value
// is available yet and which result bus (if any) should feed it.
module hazard_scoreboard_operand_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int RW         = 5,
    parameter int FW         = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic                  id_valid_i,
    input  logic                  used_i,
    input  logic [RW-1:0]         rs_i,
    output logic                  ready_o,
    output logic [FW-1:0]         fwd_o
);

    // Walking from oldest to youngest lets the youngest writer override.
    always_comb begin
        ready_o = 1'b1;
        fwd_o   = FW'(FWD_RF);
        if (id_valid_i && used_i && (rs_i != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entries_i[i].valid && (entries_i[i].rd == regbits_t'(rs_i))) begin
                    if (entries_i[i].is_load && (i < LOAD_READY)) begin
                        ready_o = 1'b0;
                        fwd_o   = FW'(FWD_RF);
                    end else begin
                        ready_o = 1'b1;
                        fwd_o   = FW'(i + 1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: shift scoreboard of in-flight writers,
// decode stall, per-operand forward selects, flush bubbles and stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS       = 32,
    parameter int DEPTH       = 3,
    parameter int LOAD_READY  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    hazard_scoreboard_if.slave   bus
);

    localparam int RW = $clog2(NREGS);
    localparam int FW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic          rdy1, rdy2;
    logic [FW-1:0] fwd1, fwd2;
    logic          stall;
    logic          alloc;

    hazard_scoreboard_operand_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW)
    ) u_match_rs1 (
        .entries_i  (entry_q),
        .id_valid_i (bus.id_valid),
        .used_i     (bus.id_rs1_used),
        .rs_i       (bus.id_rs1),
        .ready_o    (rdy1),
        .fwd_o      (fwd1)
    );

    hazard_scoreboard_operand_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .RW(RW), .FW(FW)
    ) u_match_rs2 (
        .entries_i  (entry_q),
        .id_valid_i (bus.id_valid),
        .used_i     (bus.id_rs2_used),
        .rs_i       (bus.id_rs2),
        .ready_o    (rdy2),
        .fwd_o      (fwd2)
    );

    // A taken branch squashes decode, so a flush overrides any hazard.
    assign stall = bus.id_valid & ~bus.flush & (~rdy1 | ~rdy2);
    assign alloc = bus.id_valid & bus.id_regwr & (bus.id_rd != '0) & ~stall & ~bus.flush;

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        if (bus.advance) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entry_d[i] = entry_q[i - 1];
            end
            entry_d[0].valid   = alloc;
            entry_d[0].rd      = regbits_t'(bus.id_rd);
            entry_d[0].is_load = bus.id_is_load;
            if (bus.flush) begin
                for (int i = 0; i < FLUSH_DEPTH; i++) begin
                    entry_d[i].valid = 1'b0;
                end
            end
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bus.sb_valid[i] = entry_q[i].valid;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd1      = fwd1;
    assign bus.fwd2      = fwd2;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a queue-based model of in-flight
// writers checked every cycle, plus hand-computed expectations per scenario.
module tb_hazard_scoreboard;

  localparam int NREGS       = 32;
  localparam int DEPTH       = 3;
  localparam int LOAD_READY  = 1;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  hazard_scoreboard_if #(.NREGS(NREGS), .DEPTH(DEPTH), .CNT_W(CNT_W)) sb_if ();

  hazard_scoreboard #(
    .NREGS(NREGS), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
    .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (sb_if.slave)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: m_q[0] is the youngest in-flight writer
  typedef struct {
    bit valid;
    int rd;
    bit ld;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_cnt = 0;
  bit     model_live = 0;

  function automatic void op_eval(input int rs, input bit used, output bit rdy, output int fwd);
    rdy = 1;
    fwd = 0;
    if (!(sb_if.id_valid && used && rs != 0)) return;
    for (int k = 0; k < DEPTH; k++) begin
      if (m_q[k].valid && m_q[k].rd == rs) begin
        if (m_q[k].ld && k < LOAD_READY) rdy = 0;
        else fwd = k + 1;
        return;
      end
    end
  endfunction

  function automatic void model_out(output bit st, output int f1, output int f2);
    bit r1, r2;
    op_eval(int'(sb_if.id_rs1), sb_if.id_rs1_used, r1, f1);
    op_eval(int'(sb_if.id_rs2), sb_if.id_rs2_used, r2, f2);
    st = sb_if.id_valid && !sb_if.flush && (!r1 || !r2);
  endfunction

  always @(posedge CLK) begin
    bit st;
    int f1, f2;
    m_ent_t e;
    if (RST) begin
      m_q = {};
      for (int k = 0; k < DEPTH; k++) m_q.push_back('{valid: 0, rd: 0, ld: 0});
      m_cnt = 0;
      model_live = 1;
    end else if (model_live && sb_if.advance) begin
      model_out(st, f1, f2);
      if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      e.valid = sb_if.id_valid && sb_if.id_regwr && sb_if.id_rd != 0 && !st && !sb_if.flush;
      e.rd    = int'(sb_if.id_rd);
      e.ld    = sb_if.id_is_load;
      m_q.push_front(e);
      void'(m_q.pop_back());
      if (sb_if.flush)
        for (int k = 0; k < FLUSH_DEPTH; k++) m_q[k].valid = 0;
    end
  end

  // compare process
  always @(negedge CLK) begin
    bit st;
    int f1, f2;
    logic [DEPTH-1:0] sv;
    if (model_live) begin
      model_out(st, f1, f2);
      for (int k = 0; k < DEPTH; k++) sv[k] = m_q[k].valid;
      chk("cyc_stall", 32'(sb_if.stall), 32'(st));
      chk("cyc_fwd1", 32'(sb_if.fwd1), 32'(f1));
      chk("cyc_fwd2", 32'(sb_if.fwd2), 32'(f2));
      chk("cyc_sb_valid", 32'(sb_if.sb_valid), 32'(sv));
      chk("cyc_stall_cnt", 32'(sb_if.stall_cnt), 32'(m_cnt));
    end
  end

  // driver tasks
  task automatic drive(input bit adv, input bit fl, input bit v,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld);
    sb_if.advance     = adv;
    sb_if.flush       = fl;
    sb_if.id_valid    = v;
    sb_if.id_rs1      = 5'(rs1);
    sb_if.id_rs1_used = u1;
    sb_if.id_rs2      = 5'(rs2);
    sb_if.id_rs2_used = u2;
    sb_if.id_rd       = 5'(rd);
    sb_if.id_regwr    = wr;
    sb_if.id_is_load  = ld;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_stall", 32'(sb_if.stall), 32'd0);
    chk("rst_fwd1", 32'(sb_if.fwd1), 32'd0);
    chk("rst_fwd2", 32'(sb_if.fwd2), 32'd0);
    chk("rst_sb_valid", 32'(sb_if.sb_valid), 32'd0);
    chk("rst_cnt", 32'(sb_if.stall_cnt), 32'd0);

    // ALU RAW: add x5, then add x9 reading x5, then a read of x5 from entry 1
    drive(1, 0, 1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    drive(1, 0, 1, 5, 1, 0, 0, 9, 1, 0);
    #1;
    chk("alu_fwd1_e0", 32'(sb_if.fwd1), 32'd1);
    chk("alu_stall_e0", 32'(sb_if.stall), 32'd0);
    tick();
    drive(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    chk("alu_fwd1_e1", 32'(sb_if.fwd1), 32'd2);
    tick();

    // load-use: lw x6, consumer stalls once then forwards from entry 1
    drive(1, 0, 1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    drive(1, 0, 1, 0, 0, 6, 1, 7, 1, 0);
    #1;
    chk("lu_stall", 32'(sb_if.stall), 32'd1);
    chk("lu_fwd2_wait", 32'(sb_if.fwd2), 32'd0);
    tick();
    chk("lu_bubble", 32'(sb_if.sb_valid), 32'b010);
    chk("lu_stall_clear", 32'(sb_if.stall), 32'd0);
    chk("lu_fwd2_e1", 32'(sb_if.fwd2), 32'd2);
    chk("lu_cnt", 32'(sb_if.stall_cnt), 32'd1);
    tick();

    // youngest writer wins
    drive(1, 0, 1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    drive(1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
    #1;
    chk("young_sb_valid", 32'(sb_if.sb_valid), 32'b011);
    chk("young_fwd1", 32'(sb_if.fwd1), 32'd1);
    tick();

    // x0 never allocates; unused operand never forwards
    drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("x0_sb_valid", 32'(sb_if.sb_valid), 32'b100);
    drive(1, 0, 1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    drive(1, 0, 1, 8, 0, 8, 1, 0, 0, 0);
    #1;
    chk("unused_fwd1", 32'(sb_if.fwd1), 32'd0);
    chk("used_fwd2", 32'(sb_if.fwd2), 32'd1);
    tick();

    // flush: fill x1, x2, lw x3, then flush with a hazard and a writer of x4
    drive(1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 2, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    drive(1, 0, 1, 3, 1, 0, 0, 4, 1, 0);
    #1;
    chk("fl_full", 32'(sb_if.sb_valid), 32'b111);
    chk("fl_hazard", 32'(sb_if.stall), 32'd1);
    sb_if.flush = 1'b1;
    #1;
    chk("fl_stall_masked", 32'(sb_if.stall), 32'd0);
    tick();
    chk("fl_sb_valid", 32'(sb_if.sb_valid), 32'b100);
    chk("fl_cnt", 32'(sb_if.stall_cnt), 32'd1);

    // hold: load-use hazard with advance low for 5 cycles
    drive(1, 0, 1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    drive(0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_stall", 32'(sb_if.stall), 32'd1);
      chk("hold_sb_valid", 32'(sb_if.sb_valid), 32'b001);
      chk("hold_cnt", 32'(sb_if.stall_cnt), 32'd1);
      tick();
    end
    sb_if.advance = 1'b1;
    tick();
    chk("hold_release_cnt", 32'(sb_if.stall_cnt), 32'd2);

    // counter saturation: 16 more load-use stalls on a 4-bit counter
    for (int n = 0; n < 16; n++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 10, 1, 1);
      tick();
      drive(1, 0, 1, 10, 1, 0, 0, 0, 0, 0);
      tick();
      tick();
    end
    chk("sat_cnt", 32'(sb_if.stall_cnt), 32'd15);

    // reset mid-operation, with advance low and flush high
    drive(1, 0, 1, 0, 0, 0, 0, 6, 1, 1);
    tick();
    chk("pre_rst_sb_valid", 32'(sb_if.sb_valid), 32'b001);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    tick();
    chk("midrst_sb_valid", 32'(sb_if.sb_valid), 32'd0);
    chk("midrst_cnt", 32'(sb_if.stall_cnt), 32'd0);
    RST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Tracks destination registers of in-flight instructions past decode in a DEPTH-entry shift scoreboard (entry 0 = EX, entry DEPTH-1 = last writeback stage).
- Drives decode stall, per-operand forward-source selects and branch-flush bubble insertion.
- Sits beside the pipeline latches; replaces the fixed no-interlock behaviour with configurable depth, load-use latency, flush depth and a stall counter.

Parameters:
- NREGS, 32, architectural register count; register index width RW = $clog2(NREGS).
- DEPTH, 3, scoreboard entries (pipeline stages after decode that can hold a writer).
- LOAD_READY, 1, lowest entry index at which a load result is forwardable (ALU results are forwardable from entry 0).
- FLUSH_DEPTH, 2, entries invalidated (post-shift) on flush; legal range 1..DEPTH.
- CNT_W, 32, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- advance  in  1  pipeline enable (ihit|dhit qualified); scoreboard shifts only when high.
- flush  in  1  branch/jump resolved taken; sampled only with advance.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  RW  source register indices.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- id_rd  in  RW  destination index.
- id_regwr  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- stall  out  1  hold PC and IF/ID; inject bubble into EX.
- fwd1, fwd2  out  $clog2(DEPTH+1)  0 = register file; k = entry k-1 result bus.
- sb_valid  out  DEPTH  per-entry valid, for debug and verification.
- stall_cnt  out  CNT_W  saturating count of cycles with stall & advance.

Behaviour:
- Entry fields: valid, rd[RW], is_load. Reset clears all valid bits, stall_cnt <= 0. Outputs after reset: stall=0, fwd1=fwd2=0, sb_valid=0.
- Match for operand n: id_valid & rsn_used & rsn!=0 & entry.valid & entry.rd==rsn. x0 never matches.
- Youngest match (lowest index i) wins:
  - fwdn = i+1 when data ready; otherwise fwdn=0 and the operand is not-ready.
  - Ready = !is_load | i >= LOAD_READY.
  - No match: fwdn=0.
- stall is combinational: id_valid & !flush & (rs1 not-ready | rs2 not-ready). fwd outputs are valid in the same cycle as the decode inputs, with zero latency.
- advance=1:
  - entry[i] <= entry[i-1] for i>=1; the oldest entry drops out.
  - entry[0] <= {1, id_rd, id_is_load} if id_valid & id_regwr & id_rd!=0 & !stall & !flush; else bubble (valid=0).
- flush with advance=1: after the shift, entries 0..FLUSH_DEPTH-1 have valid=0. With the default of 2, this kills the decode and EX wrong-path instructions. Entries at index >= FLUSH_DEPTH are unaffected.
- advance=0: all state holds; flush is ignored; stall and fwd stay combinationally live.
- stall_cnt increments when stall & advance and saturates at all-ones.
- Simultaneous flush and hazard: flush wins; stall=0; no entry is allocated.
- RST mid-operation: state clears on the next edge regardless of advance/flush.
- Width rule: rd comparisons are exact RW-bit equality. No wrap-around except the counter saturation above.

Decomposition:
- cpu_types_pkg gains:
  - typedef sb_entry_t {logic valid; regbits_t rd; logic is_load;}.
  - constant FWD_RF = 0.
- Sub-module operand_match (instantiated twice): scans entries for one source operand and returns {ready, fwd}. The top module holds the shift array, flush masking, stall combine and counter.

Test Plan:
1. ALU RAW: add x5 (advance), then decode reads rs1=5 -> fwd1=1, stall=0. One advance later with an unrelated decode; reading x5 again -> fwd1=2.
2. Load-use (LOAD_READY=1): lw x6 enters entry 0, decode reads rs2=6 -> stall=1, fwd2=0, bubble allocated. Next advance: entry 1 holds x6 -> stall=0, fwd2=2. stall_cnt=1.
3. Youngest priority: entry0.rd=7 (ALU), entry1.rd=7 (ALU), decode rs1=7 -> fwd1=1.
4. x0 and unused operands: entry0.rd=0 impossible (verify sb_valid[0]=0 after `add x0`). With rs1_used=0 and rs1 matching entry0 -> fwd1=0.
5. Flush: fill entries with x1,x2,x3; advance with flush=1 and a valid decode writing x4 -> sb_valid=3'b100 (x2 in entry 2); stall=0 even if a hazard is presented.
6. Hold/reset: advance=0 for 5 cycles with a load-use hazard -> sb_valid unchanged, stall=1, stall_cnt unchanged. Assert RST -> sb_valid=0, stall_cnt=0 next cycle.
